next_free_index_sel: RTL and testbench
======================================

# next_free_index_sel

Combinational free-slot selector for the packet controller's entry table. Given a bitmap of free entries (bit i = 1 means entry i is free), it reports whether any entry is free and the index of the selected free entry. Highest-index-first priority applies. It sits between the controller's entry-allocation bookkeeping and its allocation logic, which consumes the index in the same cycle.

## Interface
- `NUM_ENTRIES`, default 8: number of table entries. Must be ≥ 2.
- Index width `IDX_W` = $clog2(NUM_ENTRIES).
- Ports, clock and reset first:
  - `clk`, input, 1: system clock. One clock domain.
  - `rst`, input, 1: reset, synchronous and active-high.
  - `free_index_bitmap`, input, NUM_ENTRIES: bit i set means entry i is free.
  - `next_free_index_valid`, output, 1: at least one entry is free.
  - `next_free_index`, output, IDX_W: selected free entry index.

## Operation
- `next_free_index_valid` = OR-reduction of `free_index_bitmap`.
- `next_free_index` = position of the most-significant set bit of `free_index_bitmap`.
- Examples:
  - 8'b0000_0001 → 0
  - 8'b0000_0010 → 1
  - 8'b0000_0011 → 1
  - 8'b1000_0001 → 7
- Bitmap all-zero: `next_free_index_valid` = 0 and `next_free_index` = 0.
  - Consumers must ignore the index whenever valid is low.
- Non-power-of-two NUM_ENTRIES: indices ≥ NUM_ENTRIES are never produced.
- No internal state. The outputs are pure functions of `free_index_bitmap`.
- `clk` and `rst` exist for interface uniformity with the controller's blocks.
  - Neither affects the outputs.
  - Asserting `rst` (including mid-operation) does not force the outputs. They continue to track the bitmap.
- No X propagation from the unused index when the bitmap is zero; drive a defined 0.

## Timing
- Zero-cycle latency: outputs settle combinationally within the same cycle the bitmap changes.
- A bench sampling at the next `posedge clk` after driving the bitmap must see the final values.
- No handshake. The caller is responsible for clearing the chosen bit in its bitmap register on allocation.
- Reset value of outputs: not applicable (combinational).
  - With an all-zero bitmap held during reset, outputs read valid = 0, index = 0.
- Critical path is roughly log2(NUM_ENTRIES) levels of 2:1 select in a tree implementation. It must close at the controller clock for NUM_ENTRIES ≤ 64.

## Structure
- Shared `types` package: the index typedef sized by $clog2(NUM_ENTRIES) and the default NUM_ENTRIES constant. Packet-controller users import these.
- One natural sub-module: `msb_priority_encoder` (parameterised width, outputs valid plus index).
  - Implement as a recursive/generate binary tree. Each node merges its upper and lower halves, preferring the upper half when it is valid.
  - Pad the bitmap to the next power of two with zeros.
- The top wraps the encoder and passes through its outputs.

## Test plan
- Bitmap 8'b0000_0001 → valid = 1, index = 0.
- Bitmap 8'b0000_0010 → valid = 1, index = 1.
- Bitmap 8'b0000_0011 → valid = 1, index = 1 (MSB priority).
- Bitmap 8'b0000_0000 → valid = 0, index = 0.
- Bitmap 8'b1111_1111 → index 7.
- Bitmap 8'b1000_0000 → index 7.
- Walking-one over all 8 bits → index equals the bit position.
- Assert `rst` while the bitmap is 8'b0010_0100 → index stays 5, valid stays 1.
- NUM_ENTRIES = 5: bitmap 5'b10000 → index 4; bitmap 5'b00000 → valid = 0.

Source files
------------

// File: rtl/next_free_index_sel_pkg.sv
// Shared types for the packet controller's entry table: default table size
// and the matching entry-index type.
package next_free_index_sel_pkg;

   localparam int DEFAULT_NUM_ENTRIES = 8;
   localparam int DEFAULT_IDX_W       = $clog2(DEFAULT_NUM_ENTRIES);

   typedef logic [DEFAULT_IDX_W-1:0] idx_t;

endpackage

// File: rtl/next_free_index_sel_msb_priority_encoder.sv
// Most-significant-set-bit encoder built as a heap-indexed binary tree; each
// node prefers its upper child when that child holds a set bit.
module msb_priority_encoder #(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] in_bits,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_index
);

   localparam int LEAVES = 1 << IDX_W;

   // Node 1 is the root; node k has children 2k (lower) and 2k+1 (upper);
   // leaf LEAVES+i carries bit i. An empty subtree resolves to its lowest
   // leaf index, so an all-zero input yields index 0 rather than X.
   logic [2*LEAVES-1:1] node_vld;
   logic [IDX_W-1:0]    node_idx [1:2*LEAVES-1];

   genvar gi;
   generate
      for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
         if (gi < WIDTH) begin : g_real
            assign node_vld[LEAVES+gi] = in_bits[gi];
         end else begin : g_pad
            assign node_vld[LEAVES+gi] = 1'b0;
         end
         assign node_idx[LEAVES+gi] = IDX_W'(gi);
      end

      for (gi = 1; gi < LEAVES; gi++) begin : g_node
         assign node_vld[gi] = node_vld[2*gi+1] | node_vld[2*gi];
         assign node_idx[gi] = node_vld[2*gi+1] ? node_idx[2*gi+1] : node_idx[2*gi];
      end
   endgenerate

   assign out_valid = node_vld[1];
   assign out_index = node_idx[1];

endmodule

// File: rtl/next_free_index_sel.sv
// Free-slot selector: reports whether any table entry is free and the
// highest-indexed free entry, combinationally from the free bitmap.
module next_free_index_sel
   import next_free_index_sel_pkg::*;
#(
   parameter int NUM_ENTRIES = DEFAULT_NUM_ENTRIES,
   parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_ENTRIES-1:0] free_index_bitmap,
   output logic                   next_free_index_valid,
   output logic [IDX_W-1:0]       next_free_index
);

   // clk/rst are present only for port uniformity with neighbouring blocks.
   logic unused_clk_rst;
   assign unused_clk_rst = &{1'b0, clk, rst};

   msb_priority_encoder #(
      .WIDTH (NUM_ENTRIES),
      .IDX_W (IDX_W)
   ) u_msb_enc (
      .in_bits   (free_index_bitmap),
      .out_valid (next_free_index_valid),
      .out_index (next_free_index)
   );

endmodule

// File: tb/tb_next_free_index_sel.sv
// Scoreboard bench for next_free_index_sel: stimulus pushes hand-computed
// expectations, a monitor pops and compares at the next rising clock edge.
module tb_next_free_index_sel;

   logic       clk;
   logic       rst;
   logic [7:0] bm8;
   logic [4:0] bm5;
   logic       v8;
   logic [2:0] i8;
   logic       v5;
   logic [2:0] i5;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit         sel5;
      logic       exp_v;
      logic [2:0] exp_i;
      string      nm;
   } exp_t;

   exp_t sb[$];

   next_free_index_sel #(.NUM_ENTRIES(8)) dut8 (
      .clk                   (clk),
      .rst                   (rst),
      .free_index_bitmap     (bm8),
      .next_free_index_valid (v8),
      .next_free_index       (i8)
   );

   next_free_index_sel #(.NUM_ENTRIES(5)) dut5 (
      .clk                   (clk),
      .rst                   (rst),
      .free_index_bitmap     (bm5),
      .next_free_index_valid (v5),
      .next_free_index       (i5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive8(input logic [7:0] b, input logic ev, input logic [2:0] ei, input string nm);
      exp_t e;
      @(negedge clk);
      bm8 = b;
      e.sel5 = 1'b0; e.exp_v = ev; e.exp_i = ei; e.nm = nm;
      sb.push_back(e);
   endtask

   task automatic drive5(input logic [4:0] b, input logic ev, input logic [2:0] ei, input string nm);
      exp_t e;
      @(negedge clk);
      bm5 = b;
      e.sel5 = 1'b1; e.exp_v = ev; e.exp_i = ei; e.nm = nm;
      sb.push_back(e);
   endtask

   // Monitor: compare the oldest expectation against the DUT at each rising edge.
   initial begin
      exp_t       e;
      logic       av;
      logic [2:0] ai;
      forever begin
         @(posedge clk);
         if (sb.size() > 0) begin
            e  = sb.pop_front();
            av = e.sel5 ? v5 : v8;
            ai = e.sel5 ? i5 : i8;
            total++;
            if (av !== e.exp_v || ai !== e.exp_i) begin
               bad++;
               $display("FAIL %s: got valid=%b index=%0d, want valid=%b index=%0d",
                        e.nm, av, ai, e.exp_v, e.exp_i);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      bm8 = 8'h00;
      bm5 = 5'h00;

      drive8(8'b0000_0000, 1'b0, 3'd0, "reset_zero8");
      drive5(5'b00000, 1'b0, 3'd0, "reset_zero5");
      @(negedge clk);
      rst = 1'b0;

      drive8(8'b0000_0001, 1'b1, 3'd0, "bit0");
      drive8(8'b0000_0010, 1'b1, 3'd1, "bit1");
      drive8(8'b0000_0011, 1'b1, 3'd1, "msb_prio_low");
      drive8(8'b0000_0000, 1'b0, 3'd0, "all_zero");
      drive8(8'b1111_1111, 1'b1, 3'd7, "all_ones");
      drive8(8'b1000_0000, 1'b1, 3'd7, "top_only");
      drive8(8'b1000_0001, 1'b1, 3'd7, "top_and_bottom");
      drive8(8'b0101_0000, 1'b1, 3'd6, "mid_pair");
      drive8(8'b0000_1100, 1'b1, 3'd3, "low_pair");
      drive8(8'b0011_1110, 1'b1, 3'd5, "run_to5");

      for (int k = 0; k < 8; k++) begin
         drive8(8'b0000_0001 << k, 1'b1, 3'(k), $sformatf("walk1_%0d", k));
      end

      drive8(8'b0010_0100, 1'b1, 3'd5, "pre_rst");
      @(negedge clk);
      rst = 1'b1;
      drive8(8'b0010_0100, 1'b1, 3'd5, "during_rst");
      drive8(8'b0000_0100, 1'b1, 3'd2, "change_in_rst");
      @(negedge clk);
      rst = 1'b0;
      drive8(8'b0010_0100, 1'b1, 3'd5, "post_rst");

      drive5(5'b10000, 1'b1, 3'd4, "n5_top");
      drive5(5'b00000, 1'b0, 3'd0, "n5_zero");
      drive5(5'b00110, 1'b1, 3'd2, "n5_mid");
      drive5(5'b01001, 1'b1, 3'd3, "n5_b3");
      drive5(5'b11111, 1'b1, 3'd4, "n5_all");
      drive5(5'b00001, 1'b1, 3'd0, "n5_bit0");

      for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
